// File: rtl/rf_writeback.sv
// Write-side front end for the 8-bit register file: in-order FIFO of ALU/load
// writebacks, registered write port, overflow flag owner and pending-write mask.
module rf_writeback #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  input  logic [4:0] alu_dst,
  input  logic [7:0] alu_data,
  input  logic       alu_ovf,
  input  logic       mem_valid,
  input  logic [4:0] mem_dst,
  input  logic [7:0] mem_data,
  output logic       wb_ready,
  output logic       we,
  output logic [4:0] ptr_w,
  output logic [7:0] di,
  output logic       r_overflow,
  output logic [7:0] pend,
  output logic       empty,
  output logic       wb_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [4:0] dst;
    logic [7:0] data;
    logic       ovf_valid;
    logic       ovf;
    logic       wr;
  } wb_entry_t;

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [4:0]    r_ptr_w;
  logic [7:0]    r_di;
  logic          r_wb_err;

  logic          w_mem_req;
  logic          w_alu_wr;
  logic [CW-1:0] w_free;
  logic          w_mem_push;
  logic          w_alu_push;
  logic          w_drop;
  logic          w_pop;
  logic [PW-1:0] w_alu_slot;
  wb_entry_t     w_head;
  wb_entry_t     w_mem_entry;
  wb_entry_t     w_alu_entry;
  logic [7:0]    w_pend;

  // Loads to r0 or beyond r7 carry no architectural effect, so they never enter.
  assign w_mem_req = mem_valid && (mem_dst != 5'd0) && (mem_dst < 5'd8);
  assign w_alu_wr  = (alu_dst != 5'd0) && (alu_dst < 5'd8);

  // Free space is judged before this edge's pop; the popped slot is not reused.
  assign w_free     = DEPTH_C - r_count;
  assign w_mem_push = w_mem_req && (w_free != '0);
  assign w_alu_push = alu_valid && (w_mem_push ? (w_free >= CW'(2)) : (w_free != '0));
  assign w_drop     = (w_mem_req && !w_mem_push) || (alu_valid && !w_alu_push);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wr_ptr + PW'(w_mem_push);
  assign w_head     = r_mem[r_rd_ptr];

  assign w_mem_entry = '{dst: mem_dst, data: mem_data, ovf_valid: 1'b0, ovf: 1'b0, wr: 1'b1};
  assign w_alu_entry = '{dst: alu_dst, data: alu_data, ovf_valid: 1'b1, ovf: alu_ovf,
                         wr: w_alu_wr};

  // NOTE: FIFO storage has no reset; occupancy is tracked only by pointers and
  // count, so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_push) r_mem[r_wr_ptr] <= w_mem_entry;
    if (w_alu_push) r_mem[w_alu_slot] <= w_alu_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_ptr_w    <= '0;
      r_di       <= '0;
      r_overflow <= 1'b0;
      r_wb_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_we     <= w_head.wr;
        r_ptr_w  <= w_head.dst;
        r_di     <= w_head.data;
        r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_head.ovf_valid) r_overflow <= w_head.ovf;
      end else begin
        r_we <= 1'b0;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_mem_push) + PW'(w_alu_push);
      r_count  <= r_count - CW'(w_pop) + CW'(w_mem_push) + CW'(w_alu_push);
      if (w_drop) r_wb_err <= 1'b1;
    end
  end

  // NOTE: every bit of w_pend is assigned a default first, so no latch is inferred.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && r_mem[r_rd_ptr + PW'(i)].wr)
        w_pend[r_mem[r_rd_ptr + PW'(i)].dst[2:0]] = 1'b1;
    end
    if (r_we && (r_ptr_w < 5'd8)) w_pend[r_ptr_w[2:0]] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign wb_ready = (w_free >= CW'(2));
  assign we       = r_we;
  assign ptr_w    = r_ptr_w;
  assign di       = r_di;
  assign pend     = w_pend;
  assign empty    = (r_count == '0) && !r_we;
  assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: queue-level reference model, per-cycle
// status checks and a decoupled write-port scoreboard.
module tb_rf_writeback;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       alu_valid;
  logic [4:0] alu_dst;
  logic [7:0] alu_data;
  logic       alu_ovf;
  logic       mem_valid;
  logic [4:0] mem_dst;
  logic [7:0] mem_data;
  logic       wb_ready;
  logic       we;
  logic [4:0] ptr_w;
  logic [7:0] di;
  logic       r_overflow;
  logic [7:0] pend;
  logic       empty;
  logic       wb_err;

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ovf(alu_ovf),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_ready(wb_ready), .we(we), .ptr_w(ptr_w), .di(di), .r_overflow(r_overflow),
    .pend(pend), .empty(empty), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] dst;
    logic [7:0] data;
    bit         ovf_valid;
    bit         ovf;
    bit         wr;
  } ent_t;

  typedef struct {
    logic [4:0] ptr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  // Reference model state: queued requests plus architectural outputs.
  ent_t       q[$];
  exp_t       exp_q[$];
  bit         m_we;
  logic [4:0] m_ptr;
  logic [7:0] m_di;
  bit         m_ovf;
  bit         m_err;
  logic [7:0] rf [8];
  int         cyc;
  int         n_checks;
  int         n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, predict the edge, then compare status outputs.
  task automatic step(input bit rst, input bit av, input logic [4:0] ad, input logic [7:0] adat,
                      input bit ao, input bit mv, input logic [4:0] md, input logic [7:0] mdat);
    int         free;
    ent_t       h;
    logic [7:0] p;
    reset = rst; alu_valid = av; alu_dst = ad; alu_data = adat; alu_ovf = ao;
    mem_valid = mv; mem_dst = md; mem_data = mdat;
    if (rst) begin
      q.delete();
      m_we = 0; m_ptr = '0; m_di = '0; m_ovf = 0; m_err = 0;
    end else begin
      free = DEPTH - q.size();
      if (q.size() > 0) begin
        h = q.pop_front();
        m_we = h.wr; m_ptr = h.dst; m_di = h.data;
        if (h.ovf_valid) m_ovf = h.ovf;
        if (h.wr) exp_q.push_back('{ptr: h.dst, data: h.data, cyc: cyc + 1});
      end else begin
        m_we = 0;
      end
      if (mv && md >= 5'd1 && md <= 5'd7) begin
        if (free > 0) begin q.push_back('{md, mdat, 1'b0, 1'b0, 1'b1}); free--; end
        else m_err = 1;
      end
      if (av) begin
        if (free > 0) begin q.push_back('{ad, adat, 1'b1, ao, (ad >= 5'd1 && ad <= 5'd7)}); free--; end
        else m_err = 1;
      end
    end
    p = '0;
    foreach (q[i]) if (q[i].wr) p[q[i].dst[2:0]] = 1'b1;
    if (m_we) p[m_ptr[2:0]] = 1'b1;
    @(posedge clk);
    #1;
    check("we", we, m_we);
    check("ptr_w", ptr_w, m_ptr);
    check("di", di, m_di);
    check("r_overflow", r_overflow, m_ovf);
    check("wb_err", wb_err, m_err);
    check("pend", pend, p);
    check("empty", empty, (q.size() == 0) && !m_we);
    check("wb_ready", wb_ready, (DEPTH - q.size()) >= 2);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && (q.size() != 0 || m_we); k++) idle();
  endtask

  // Write-port scoreboard: pops an expectation whenever the DUT writes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (we) begin
        rf[ptr_w[2:0]] = di;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_we", we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_ptr_w", ptr_w, e.ptr);
          check("sb_di", di, e.data);
          check("sb_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("sb_missing_we", we, 1'b1);
      end
    end
  end

  initial begin
    bit         av, mv, obey;
    logic [4:0] ad, md;
    cyc = 0; n_checks = 0; n_errors = 0;
    reset = 1; alu_valid = 0; alu_dst = '0; alu_data = '0; alu_ovf = 0;
    mem_valid = 0; mem_dst = '0; mem_data = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    @(negedge clk);
    step(1, 1, 5'd3, 8'hEE, 1, 1, 5'd4, 8'hDD);
    step(1, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    // Single ALU write into an idle block.
    step(0, 1, 5'd3, 8'h5A, 1, 0, 5'd0, 8'h00);
    drain();
    idle();

    // Same-cycle mem and ALU writes to r2: load first, ALU last.
    step(0, 1, 5'd2, 8'h22, 0, 1, 5'd2, 8'h11);
    drain();
    check("r2_final", rf[2], 8'h22);

    // ALU to r0 updates overflow only; load to r9 is discarded.
    step(0, 1, 5'd0, 8'h77, 1, 0, 5'd0, 8'h00);
    drain();
    step(0, 0, 5'd0, 8'h00, 0, 1, 5'd9, 8'h33);
    drain();

    // Overfill: two pushes per cycle for three cycles, ignoring wb_ready.
    for (int k = 0; k < 3; k++)
      step(0, 1, 5'(1 + k), 8'(8'hA0 + k), k[0], 1, 5'(4 + k), 8'(8'hB0 + k));
    drain();
    idle();

    // Reset with entries queued.
    step(0, 1, 5'd5, 8'h55, 0, 1, 5'd6, 8'h66);
    step(0, 1, 5'd7, 8'h77, 1, 1, 5'd1, 8'h01);
    step(1, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    idle();
    idle();
    idle();

    // Full-rate alternating overflow to registers 1..7.
    for (int k = 0; k < 14; k++)
      step(0, 1, 5'(1 + (k % 7)), 8'(k * 17), k[0] == 1'b0, 0, 5'd0, 8'h00);
    drain();

    // Randomized traffic, mostly respecting wb_ready, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      obey = ($urandom_range(0, 3) != 0);
      av = ($urandom_range(0, 2) != 0);
      mv = ($urandom_range(0, 1) != 0);
      if (obey && !wb_ready) begin av = 0; mv = 0; end
      ad = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 7));
      md = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 7));
      step($urandom_range(0, 79) == 0, av, ad, 8'($urandom), 1'($urandom), mv, md, 8'($urandom));
    end
    drain();
    idle();
    check("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
